rst_teardown_seq: RTL and testbench
===================================

Name: rst_teardown_seq

Overview:
- Warm-reset teardown sequencer: the counterpart to the power-up reset release chain.
- On a request, it drains the core pipeline, asserts domain resets in reverse order (core, then sys, then ddr), holds them, and releases them in forward order (ddr, sys, core) with fixed gaps.
- Lives in the always-on sys_clk domain. It is never reset by its own outputs.
- Destination-domain synchronizers are outside this block.

Parameters:
- STAGE_GAP, 100: cycles between consecutive reset assert/release stages.
- HOLD_CYCLES, 16: cycles all three resets stay asserted together.
- DRAIN_TIMEOUT, 4096: maximum cycles to wait for i_core_idle (used only with the optional feature).
- CNT_W, 13: counter width. Must satisfy 2^CNT_W > max(STAGE_GAP, HOLD_CYCLES, DRAIN_TIMEOUT).

Ports:
- i_sys_clk  in  1  single clock.
- i_sys_reset  in  1  synchronous, active-high reset.
- i_req  in  1  single-cycle teardown request.
- i_core_idle  in  1  core reports empty pipeline / no outstanding memory traffic.
- o_drain_req  out  1  asks core to stop accepting new work.
- o_core_reset  out  1  active-high core reset.
- o_sys_rstn  out  1  active-low sys-domain reset.
- o_ddr_rstn  out  1  active-low ddr reset.
- o_busy  out  1  sequence in progress.
- o_done  out  1  one-cycle pulse when sequence completes.
- o_timeout  out  1  sticky: drain timed out. Cleared on next accepted i_req or on reset.

Behaviour:
- Reset values (i_sys_reset=1, sampled on clock edge):
  - state=IDLE, counter=0.
  - o_drain_req=0, o_core_reset=0, o_sys_rstn=1, o_ddr_rstn=1, o_busy=0, o_done=0, o_timeout=0.
- All outputs are registered. No combinational path from inputs to outputs.
- States and transitions:
  - IDLE: i_req=1 → DRAIN. Counter cleared, o_drain_req=1 and o_busy=1 from the next cycle.
  - DRAIN: i_core_idle=1 → ASSERT_CORE. Timeout handling is under the optional feature.
  - ASSERT_CORE: o_core_reset=1. After STAGE_GAP cycles → ASSERT_SYS.
  - ASSERT_SYS: o_sys_rstn=0. After STAGE_GAP cycles → ASSERT_DDR.
  - ASSERT_DDR: o_ddr_rstn=0. After HOLD_CYCLES cycles → REL_DDR. o_drain_req drops on entry to ASSERT_DDR.
  - REL_DDR: o_ddr_rstn=1. After STAGE_GAP → REL_SYS.
  - REL_SYS: o_sys_rstn=1. After STAGE_GAP → REL_CORE.
  - REL_CORE: o_core_reset=0. After STAGE_GAP → DONE.
  - DONE: o_done=1 for exactly one cycle, o_busy=0 → IDLE.
- Each output changes on the first cycle of its state. A gap of N means the next change occurs exactly N cycles later.
- Counter counts 0..N-1 and clears on every state change. It never wraps within a state.
- i_req while o_busy=1: ignored, not queued.
- i_req in the same cycle o_done=1: ignored. A new request needs i_req in IDLE.
- i_core_idle sampled only in DRAIN. Its value in other states is don't-care.
- i_sys_reset mid-sequence: all outputs return to reset values on the next edge, so resets release immediately. The caller owns that hazard.

Optional Feature:
- Macro: RST_TEARDOWN_TIMEOUT_EN.
- Defined: a DRAIN counter runs. If i_core_idle has not been seen by DRAIN_TIMEOUT cycles, the block sets o_timeout=1 and proceeds to ASSERT_CORE (forced teardown). If i_core_idle and the timeout occur in the same cycle, idle wins and o_timeout stays 0.
- Undefined: DRAIN waits indefinitely, o_timeout is tied 0, and the DRAIN_TIMEOUT parameter is unused.

Decomposition:
- Shared package rst_seq_pkg holds:
  - state enum (IDLE, DRAIN, ASSERT_CORE, ASSERT_SYS, ASSERT_DDR, REL_DDR, REL_SYS, REL_CORE, DONE);
  - default constants STAGE_GAP=100, HOLD_CYCLES=16, DRAIN_TIMEOUT=4096.
- One sub-module, rst_stage_timer:
  - loadable down-counter with clear and a terminal-count pulse;
  - shared by all timed states and by the drain timeout.

Test Plan:
- Basic sequence (i_core_idle=1 from start, i_req pulse at cycle 10, parameters at defaults):
  - o_core_reset rises at 12, o_sys_rstn falls at 112, o_ddr_rstn falls at 212;
  - ddr released at 228, sys at 328, core at 428;
  - o_done pulse at 528 (±1 per documented register stage, checked exactly against the state table).
- Delayed drain: i_core_idle rises 500 cycles after i_req → o_core_reset rises 1 cycle later; o_timeout=0.
- Timeout (RST_TEARDOWN_TIMEOUT_EN defined, i_core_idle=0):
  - o_timeout=1 and o_core_reset=1 exactly DRAIN_TIMEOUT cycles after DRAIN entry;
  - next i_req clears o_timeout.
- Repeat requests: i_req pulsed at 5 random points during o_busy=1 → exactly one o_done; all edge times unchanged.
- Mid-sequence reset: i_sys_reset=1 during ASSERT_DDR → next cycle o_core_reset=0, o_sys_rstn=1, o_ddr_rstn=1, o_busy=0; a subsequent i_req runs a full clean sequence.
- Ordering assertions, checked throughout every run:
  - o_ddr_rstn=0 implies o_sys_rstn=0;
  - o_sys_rstn=0 implies o_core_reset=1;
  - the two ddr/sys transitions are never in the same cycle.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and defaults for the warm-reset teardown sequencer.
// Holds the state enum, output bundle and the per-state output decode.
package rst_seq_pkg;

    localparam int STAGE_GAP     = 100;
    localparam int HOLD_CYCLES   = 16;
    localparam int DRAIN_TIMEOUT = 4096;
    localparam int CNT_W         = 13;

    typedef enum logic [3:0] {
        IDLE,
        DRAIN,
        ASSERT_CORE,
        ASSERT_SYS,
        ASSERT_DDR,
        REL_DDR,
        REL_SYS,
        REL_CORE,
        DONE
    } rst_state_e;

    typedef struct packed {
        logic drain_req;
        logic core_reset;
        logic sys_rstn;
        logic ddr_rstn;
        logic busy;
        logic done;
    } rst_out_t;

    localparam rst_out_t RST_OUT_IDLE = '{
        drain_req:  1'b0,
        core_reset: 1'b0,
        sys_rstn:   1'b1,
        ddr_rstn:   1'b1,
        busy:       1'b0,
        done:       1'b0
    };

    // Output levels held for the whole time the sequencer sits in a state.
    function automatic rst_out_t state_outputs(input rst_state_e s);
        rst_out_t r;
        r = RST_OUT_IDLE;
        unique case (s)
            DRAIN: begin
                r.drain_req = 1'b1;
                r.busy      = 1'b1;
            end
            ASSERT_CORE: begin
                r.drain_req  = 1'b1;
                r.busy       = 1'b1;
                r.core_reset = 1'b1;
            end
            ASSERT_SYS: begin
                r.drain_req  = 1'b1;
                r.busy       = 1'b1;
                r.core_reset = 1'b1;
                r.sys_rstn   = 1'b0;
            end
            ASSERT_DDR: begin
                r.busy       = 1'b1;
                r.core_reset = 1'b1;
                r.sys_rstn   = 1'b0;
                r.ddr_rstn   = 1'b0;
            end
            REL_DDR: begin
                r.busy       = 1'b1;
                r.core_reset = 1'b1;
                r.sys_rstn   = 1'b0;
            end
            REL_SYS: begin
                r.busy       = 1'b1;
                r.core_reset = 1'b1;
            end
            REL_CORE: begin
                r.busy = 1'b1;
            end
            DONE: begin
                r.done = 1'b1;
            end
            default: r = RST_OUT_IDLE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rst_stage_timer.sv
// Loadable down-counter with clear and a one-shot terminal-count pulse.
// Shared by every timed state of the teardown sequencer.
module rst_stage_timer #(
    parameter int CNT_W = 13
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_tc
);

    localparam logic [CNT_W-1:0] ONE = 1;

    logic [CNT_W-1:0] cnt_q;
    logic             run_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (i_load) begin
            cnt_q <= i_load_val;
            run_q <= 1'b1;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - ONE;
        end else begin
            // Fire once, then stay quiet until reloaded.
            run_q <= 1'b0;
        end
    end

    assign o_tc = run_q && (cnt_q == '0);

endmodule

// File: rtl/rst_teardown_seq.sv
// Warm-reset teardown sequencer: drain, assert core/sys/ddr, release ddr/sys/core.
// Optional drain timeout enabled with `define RST_TEARDOWN_TIMEOUT_EN.
module rst_teardown_seq #(
    parameter int STAGE_GAP     = rst_seq_pkg::STAGE_GAP,
    parameter int HOLD_CYCLES   = rst_seq_pkg::HOLD_CYCLES,
    parameter int DRAIN_TIMEOUT = rst_seq_pkg::DRAIN_TIMEOUT,
    parameter int CNT_W         = rst_seq_pkg::CNT_W
) (
    input  logic i_sys_clk,
    input  logic i_sys_reset,
    input  logic i_req,
    input  logic i_core_idle,
    output logic o_drain_req,
    output logic o_core_reset,
    output logic o_sys_rstn,
    output logic o_ddr_rstn,
    output logic o_busy,
    output logic o_done,
    output logic o_timeout
);

    import rst_seq_pkg::*;

    localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_DRAIN = CNT_W'(DRAIN_TIMEOUT - 1);

    rst_state_e       state_q;
    rst_state_e       state_d;
    rst_out_t         out_q;
    logic             tmr_tc;
    logic             tmr_load;
    logic             tmr_clr;
    logic [CNT_W-1:0] tmr_val;
`ifdef RST_TEARDOWN_TIMEOUT_EN
    logic             to_hit;
    logic             req_acc;
    logic             timeout_q;
`endif

    always_comb begin
        state_d = state_q;
`ifdef RST_TEARDOWN_TIMEOUT_EN
        to_hit  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (i_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (i_core_idle) begin
                    state_d = ASSERT_CORE;
`ifdef RST_TEARDOWN_TIMEOUT_EN
                end else if (tmr_tc) begin
                    state_d = ASSERT_CORE;
                    to_hit  = 1'b1;
`endif
                end
            end
            ASSERT_CORE: begin
                if (tmr_tc) state_d = ASSERT_SYS;
            end
            ASSERT_SYS: begin
                if (tmr_tc) state_d = ASSERT_DDR;
            end
            ASSERT_DDR: begin
                if (tmr_tc) state_d = REL_DDR;
            end
            REL_DDR: begin
                if (tmr_tc) state_d = REL_SYS;
            end
            REL_SYS: begin
                if (tmr_tc) state_d = REL_CORE;
            end
            REL_CORE: begin
                if (tmr_tc) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Timer is reloaded on the same edge the new state is entered.
    always_comb begin
        tmr_val = '0;
        unique case (state_d)
            DRAIN:       tmr_val = LD_DRAIN;
            ASSERT_DDR:  tmr_val = LD_HOLD;
            ASSERT_CORE,
            ASSERT_SYS,
            REL_DDR,
            REL_SYS,
            REL_CORE:    tmr_val = LD_GAP;
            default:     tmr_val = '0;
        endcase
    end

    assign tmr_load = (state_d != state_q);
    assign tmr_clr  = (state_d == IDLE);

    rst_stage_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk      (i_sys_clk),
        .i_rst      (i_sys_reset),
        .i_clr      (tmr_clr),
        .i_load     (tmr_load),
        .i_load_val (tmr_val),
        .o_tc       (tmr_tc)
    );

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs decoded from the next state so each changes on its state's first cycle.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_reset) begin
            out_q <= RST_OUT_IDLE;
        end else begin
            out_q <= state_outputs(state_d);
        end
    end

`ifdef RST_TEARDOWN_TIMEOUT_EN
    assign req_acc = (state_q == IDLE) && i_req;

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_reset) begin
            timeout_q <= 1'b0;
        end else if (req_acc) begin
            timeout_q <= 1'b0;
        end else if (to_hit) begin
            timeout_q <= 1'b1;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    assign o_drain_req  = out_q.drain_req;
    assign o_core_reset = out_q.core_reset;
    assign o_sys_rstn   = out_q.sys_rstn;
    assign o_ddr_rstn   = out_q.ddr_rstn;
    assign o_busy       = out_q.busy;
    assign o_done       = out_q.done;

endmodule

// File: tb/tb_rst_teardown_seq.sv
// Directed bench for rst_teardown_seq with an edge-event scoreboard.
// Covers the RST_TEARDOWN_TIMEOUT_EN build when that macro is defined.
module tb_rst_teardown_seq;

    localparam int K_BUSY_UP  = 0;
    localparam int K_DRAIN_UP = 1;
    localparam int K_CORE_UP  = 2;
    localparam int K_SYS_DN   = 3;
    localparam int K_DRAIN_DN = 4;
    localparam int K_DDR_DN   = 5;
    localparam int K_DDR_UP   = 6;
    localparam int K_SYS_UP   = 7;
    localparam int K_CORE_DN  = 8;
    localparam int K_BUSY_DN  = 9;
    localparam int K_DONE_UP  = 10;
    localparam int K_DONE_DN  = 11;

    typedef struct {
        int kind;
        int at;
    } ev_t;

    logic clk = 1'b0;
    logic i_sys_reset = 1'b1;
    logic i_req = 1'b0;
    logic i_core_idle = 1'b1;
    logic o_drain_req, o_core_reset, o_sys_rstn, o_ddr_rstn;
    logic o_busy, o_done, o_timeout;

    int  vec = 0;
    int  miss = 0;
    int  edge_n = 0;
    bit  mon_en = 1'b0;
    logic rst_edge = 1'b1;
    ev_t exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        edge_n   <= edge_n + 1;
        rst_edge <= i_sys_reset;
    end

    rst_teardown_seq dut (
        .i_sys_clk    (clk),
        .i_sys_reset  (i_sys_reset),
        .i_req        (i_req),
        .i_core_idle  (i_core_idle),
        .o_drain_req  (o_drain_req),
        .o_core_reset (o_core_reset),
        .o_sys_rstn   (o_sys_rstn),
        .o_ddr_rstn   (o_ddr_rstn),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_timeout    (o_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vec++;
        assert (got === exp) else begin
            miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    // Full sequence: request sampled at edge r, core reset asserted at edge c.
    task automatic push_seq(input int r, input int c);
        push(K_BUSY_UP,  r);
        push(K_DRAIN_UP, r);
        push(K_CORE_UP,  c);
        push(K_SYS_DN,   c + 100);
        push(K_DRAIN_DN, c + 200);
        push(K_DDR_DN,   c + 200);
        push(K_DDR_UP,   c + 216);
        push(K_SYS_UP,   c + 316);
        push(K_CORE_DN,  c + 416);
        push(K_BUSY_DN,  c + 516);
        push(K_DONE_UP,  c + 516);
        push(K_DONE_DN,  c + 517);
    endtask

    task automatic check_ev(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            vec++;
            miss++;
            $error("FAIL unexpected_event: observed kind %0d at edge %0d expected none",
                   kind, edge_n);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_edge", edge_n, e.at);
        end
    endtask

    task automatic wait_until_edge(input int e);
        while (edge_n < e) @(negedge clk);
    endtask

    task automatic drain_queue(input string tag, input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    logic p_busy, p_drain, p_core, p_sys, p_ddr, p_done;

    always @(negedge clk) begin
        logic [11:0] ch;
        ch = '0;
        ch[K_BUSY_UP]  = o_busy & ~p_busy;
        ch[K_DRAIN_UP] = o_drain_req & ~p_drain;
        ch[K_CORE_UP]  = o_core_reset & ~p_core;
        ch[K_SYS_DN]   = ~o_sys_rstn & p_sys;
        ch[K_DRAIN_DN] = ~o_drain_req & p_drain;
        ch[K_DDR_DN]   = ~o_ddr_rstn & p_ddr;
        ch[K_DDR_UP]   = o_ddr_rstn & ~p_ddr;
        ch[K_SYS_UP]   = o_sys_rstn & ~p_sys;
        ch[K_CORE_DN]  = ~o_core_reset & p_core;
        ch[K_BUSY_DN]  = ~o_busy & p_busy;
        ch[K_DONE_UP]  = o_done & ~p_done;
        ch[K_DONE_DN]  = ~o_done & p_done;
        if (mon_en) begin
            for (int k = 0; k < 12; k++) begin
                if (ch[k]) check_ev(k);
            end
            chk("ord_ddr_implies_sys", {31'b0, ~o_ddr_rstn & o_sys_rstn}, 0);
            chk("ord_sys_implies_core", {31'b0, ~o_sys_rstn & ~o_core_reset}, 0);
            if (!rst_edge) begin
                chk("ord_ddr_sys_same_cycle",
                    {31'b0, (o_ddr_rstn ^ p_ddr) & (o_sys_rstn ^ p_sys)}, 0);
            end
        end
        p_busy  = o_busy;
        p_drain = o_drain_req;
        p_core  = o_core_reset;
        p_sys   = o_sys_rstn;
        p_ddr   = o_ddr_rstn;
        p_done  = o_done;
    end

    initial begin
        int r;
        int c;
        int rr;
        int pts[5];

        repeat (3) @(negedge clk);
        chk("rst_drain_req",  o_drain_req,  0);
        chk("rst_core_reset", o_core_reset, 0);
        chk("rst_sys_rstn",   o_sys_rstn,   1);
        chk("rst_ddr_rstn",   o_ddr_rstn,   1);
        chk("rst_busy",       o_busy,       0);
        chk("rst_done",       o_done,       0);
        chk("rst_timeout",    o_timeout,    0);
        i_sys_reset = 1'b0;
        mon_en = 1'b1;
        repeat (8) @(negedge clk);

        // Basic sequence, idle from the start.
        r = edge_n + 1;
        c = r + 1;
        push_seq(r, c);
        i_req = 1'b1;
        @(negedge clk);
        i_req = 1'b0;
        chk("basic_busy_first", o_busy, 1);
        wait_until_edge(c + 200);
        chk("basic_ddr_low", o_ddr_rstn, 0);
        wait_until_edge(c + 530);
        drain_queue("basic_queue_empty", 20);
        chk("basic_timeout", o_timeout, 0);

        // Delayed drain: idle arrives 500 cycles after the request.
        i_core_idle = 1'b0;
        @(negedge clk);
        r = edge_n + 1;
        c = r + 500;
        push_seq(r, c);
        i_req = 1'b1;
        @(negedge clk);
        i_req = 1'b0;
        wait_until_edge(r + 499);
        chk("delay_core_held", o_core_reset, 0);
        chk("delay_drain_req", o_drain_req, 1);
        i_core_idle = 1'b1;
        @(negedge clk);
        chk("delay_core_up", o_core_reset, 1);
        chk("delay_timeout", o_timeout, 0);
        wait_until_edge(c + 530);
        drain_queue("delay_queue_empty", 20);

        // Repeat requests while busy and during the done cycle are dropped.
        @(negedge clk);
        r = edge_n + 1;
        c = r + 1;
        push_seq(r, c);
        for (int i = 0; i < 5; i++) begin
            pts[i] = r + 1 + i * 100 + int'($urandom_range(0, 99));
        end
        i_req = 1'b1;
        @(negedge clk);
        i_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_until_edge(pts[i] - 1);
            i_req = 1'b1;
            @(negedge clk);
            i_req = 1'b0;
        end
        wait_until_edge(c + 516);
        chk("repeat_done_high", o_done, 1);
        i_req = 1'b1;
        @(negedge clk);
        i_req = 1'b0;
        wait_until_edge(c + 540);
        drain_queue("repeat_queue_empty", 20);
        chk("repeat_idle_busy", o_busy, 0);

        // Drain with idle held low for a long time.
        i_core_idle = 1'b0;
        @(negedge clk);
        r = edge_n + 1;
`ifdef RST_TEARDOWN_TIMEOUT_EN
        c = r + 4096;
        push_seq(r, c);
        i_req = 1'b1;
        @(negedge clk);
        i_req = 1'b0;
        wait_until_edge(c - 1);
        chk("to_core_before", o_core_reset, 0);
        chk("to_flag_before", o_timeout, 0);
        @(negedge clk);
        chk("to_core_at", o_core_reset, 1);
        chk("to_flag_at", o_timeout, 1);
        i_core_idle = 1'b1;
        wait_until_edge(c + 530);
        drain_queue("to_queue_empty", 20);
        chk("to_flag_sticky", o_timeout, 1);
`else
        c = r + 4200;
        push_seq(r, c);
        i_req = 1'b1;
        @(negedge clk);
        i_req = 1'b0;
        wait_until_edge(r + 4150);
        chk("wait_core_held", o_core_reset, 0);
        chk("wait_drain_req", o_drain_req, 1);
        chk("wait_timeout", o_timeout, 0);
        wait_until_edge(c - 1);
        i_core_idle = 1'b1;
        wait_until_edge(c + 530);
        drain_queue("wait_queue_empty", 20);
`endif

        // Next request clears the timeout flag and runs cleanly.
        @(negedge clk);
        r = edge_n + 1;
        c = r + 1;
        push_seq(r, c);
        i_req = 1'b1;
        @(negedge clk);
        i_req = 1'b0;
        chk("rereq_timeout_clear", o_timeout, 0);
        wait_until_edge(c + 530);
        drain_queue("rereq_queue_empty", 20);

        // Reset in the middle of ASSERT_DDR.
        @(negedge clk);
        r = edge_n + 1;
        c = r + 1;
        push_seq(r, c);
        i_req = 1'b1;
        @(negedge clk);
        i_req = 1'b0;
        wait_until_edge(c + 205);
        chk("mid_in_ddr", o_ddr_rstn, 0);
        exp_q.delete();
        rr = edge_n + 1;
        push(K_DDR_UP,  rr);
        push(K_SYS_UP,  rr);
        push(K_CORE_DN, rr);
        push(K_BUSY_DN, rr);
        i_sys_reset = 1'b1;
        @(negedge clk);
        chk("mid_core_reset", o_core_reset, 0);
        chk("mid_sys_rstn",   o_sys_rstn,   1);
        chk("mid_ddr_rstn",   o_ddr_rstn,   1);
        chk("mid_busy",       o_busy,       0);
        chk("mid_drain_req",  o_drain_req,  0);
        i_sys_reset = 1'b0;
        drain_queue("mid_rst_events", 5);
        repeat (4) @(negedge clk);
        r = edge_n + 1;
        c = r + 1;
        push_seq(r, c);
        i_req = 1'b1;
        @(negedge clk);
        i_req = 1'b0;
        wait_until_edge(c + 530);
        drain_queue("post_rst_queue_empty", 20);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
